audio_pwm_dac: RTL and testbench

AUDIO_PWM_DAC -- requirements
Module: audio_pwm_dac

---
 rtl/audio_pwm_dac_if.sv | 21 ++
 rtl/audio_pwm_dac.sv | 103 ++++++++++
 tb/tb_audio_pwm_dac.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pwm_dac_if.sv
// Sample streaming handshake between an audio source and the PWM/sigma-delta DAC.
// The source drives sample_in/sample_valid; the DAC returns sample_ready.
interface audio_pwm_dac_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_pwm_dac.sv
// Audio DAC: one-entry sample buffer feeding a PWM or first-order sigma-delta modulator,
// paced by a programmable prescaler. Duty and mode change only on period boundaries.
module audio_pwm_dac #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               enable,
  input  logic               mode,
  input  logic [1:0]         gain,
  input  logic [DIV_W-1:0]   div,
  audio_pwm_dac_if.slave     smp,
  input  logic               underrun_clr,
  output logic               underrun,
  output logic               period_strobe,
  output logic               PWM_OUT
);

  logic [DIV_W-1:0] presc_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full_q;
  logic             mode_q;
  logic             underrun_q;
  logic             pwm_q;

  logic             tick;
  logic             boundary;
  logic             transfer;
  logic [WIDTH+2:0] shifted;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH:0]   sd_sum;

  always_comb begin
    // >= rather than == so a div lowered mid-count cannot run the prescaler through its wrap
    tick     = enable && (presc_q >= div);
    boundary = tick && (cnt_q == {WIDTH{1'b1}});
    transfer = smp.sample_valid && !buf_full_q;
    shifted  = {3'b000, smp.sample_in} << gain;
    sat_val  = (shifted[WIDTH+2:WIDTH] != 3'b000) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
    sd_sum   = {1'b0, acc_q} + {1'b0, duty_q};
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      duty_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      mode_q     <= 1'b0;
      underrun_q <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      if (!enable) begin
        presc_q <= '0;
        cnt_q   <= '0;
        acc_q   <= '0;
        pwm_q   <= 1'b0;
      end else begin
        presc_q <= tick ? '0 : presc_q + DIV_W'(1);
        if (tick) begin
          cnt_q <= cnt_q + WIDTH'(1);
          if (mode_q) begin
            pwm_q <= sd_sum[WIDTH];
            acc_q <= sd_sum[WIDTH-1:0];
          end else begin
            pwm_q <= (cnt_q < duty_q);
          end
        end
      end

      if (boundary) begin
        mode_q <= mode;
      end

      // A sample arriving on the boundary clock lands in the buffer; the boundary saw it empty.
      if (boundary && buf_full_q) begin
        duty_q     <= buf_q;
        buf_full_q <= 1'b0;
      end else if (transfer) begin
        buf_q      <= sat_val;
        buf_full_q <= 1'b1;
      end

      if (boundary && !buf_full_q) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

  assign smp.sample_ready = ~buf_full_q;
  assign underrun         = underrun_q;
  assign period_strobe    = boundary;
  assign PWM_OUT          = pwm_q;

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Directed bench for audio_pwm_dac: table of gain/saturation vectors measured as duty per
// period, plus hand-written sequences for buffering, underrun, sigma-delta, prescaler and reset.
module tb_audio_pwm_dac;

  logic       clk = 1'b0;
  logic       RST;
  logic       enable;
  logic       mode;
  logic [1:0] gain;
  logic [3:0] div;
  logic       underrun_clr;
  logic       underrun;
  logic       period_strobe;
  logic       PWM_OUT;

  audio_pwm_dac_if #(.WIDTH(8)) bus ();

  audio_pwm_dac #(.WIDTH(8), .DIV_W(4)) dut (
    .clk          (clk),
    .RST          (RST),
    .enable       (enable),
    .mode         (mode),
    .gain         (gain),
    .div          (div),
    .smp          (bus),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .period_strobe(period_strobe),
    .PWM_OUT      (PWM_OUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sample;
    logic [1:0] gain;
    int         exp_duty;
  } vec_t;

  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns the number of falling edges until period_strobe is seen, or -1 on timeout.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strobe && n < 5000);
    if (!period_strobe) n = -1;
  endtask

  task automatic count_high(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      @(negedge clk);
      ones += int'(PWM_OUT);
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [1:0] g);
    int k = 0;
    while (!bus.sample_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("send_ready", int'(bus.sample_ready), 1);
    gain             = g;
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    int n;
    int ones;
    int prev;
    int trans;
    int offp;
    int per;

    vecs[0] = '{8'd100, 2'd2, 255};
    vecs[1] = '{8'd100, 2'd1, 200};
    vecs[2] = '{8'd255, 2'd0, 255};
    vecs[3] = '{8'd0,   2'd0, 0};
    vecs[4] = '{8'd40,  2'd2, 160};
    vecs[5] = '{8'd70,  2'd2, 255};
    vecs[6] = '{8'd3,   2'd3, 24};
    vecs[7] = '{8'd31,  2'd3, 248};
    vecs[8] = '{8'd32,  2'd3, 255};
    vecs[9] = '{8'd64,  2'd0, 64};

    RST              = 1'b1;
    enable           = 1'b0;
    mode             = 1'b0;
    gain             = 2'd0;
    div              = 4'd0;
    underrun_clr     = 1'b0;
    bus.sample_in    = 8'd200;
    bus.sample_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(PWM_OUT), 0);
    check("rst_strobe", int'(period_strobe), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_ready", int'(bus.sample_ready), 1);
    RST              = 1'b0;
    bus.sample_valid = 1'b0;
    @(negedge clk);
    check("rst_valid_dropped", int'(bus.sample_ready), 1);

    // Buffer accepts one sample while stopped; no boundaries happen.
    send(8'd64, 2'd0);
    check("en0_accept", int'(bus.sample_ready), 0);
    count_high(5, ones);
    check("en0_pwm_low", ones, 0);
    check("en0_still_full", int'(bus.sample_ready), 0);
    check("en0_underrun", int'(underrun), 0);

    // First boundary is the 256th tick clock after enable rises.
    enable = 1'b1;
    wait_strobe(n);
    check("first_boundary", n, 255);
    count_high(256, ones);
    check("duty64_pwm", ones, 64);
    check("period_256", int'(period_strobe), 1);

    // Sample arriving on the boundary clock: boundary sees empty, sample stays buffered.
    send(8'd100, 2'd1);
    check("coincident_underrun", int'(underrun), 1);
    check("coincident_buffered", int'(bus.sample_ready), 0);
    count_high(255, ones);
    check("underrun_repeat_duty", ones, 64);
    check("period_strobe_2", int'(period_strobe), 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_clr", int'(underrun), 0);
    check("ready_after_load", int'(bus.sample_ready), 1);
    count_high(255, ones);
    check("gain1_duty", ones, 200);
    check("period_strobe_3", int'(period_strobe), 1);
    // Clear coincident with a fresh underrun event: set wins.
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("clr_vs_set", int'(underrun), 1);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].sample, vecs[i].gain);
      wait_strobe(n);
      count_high(256, ones);
      check($sformatf("vec%0d_duty", i), ones, vecs[i].exp_duty);
      check($sformatf("vec%0d_period", i), int'(period_strobe), 1);
    end

    // Mode change mid-period is deferred to the next boundary.
    send(8'd128, 2'd0);
    mode = 1'b1;
    count_high(16, ones);
    check("mode_deferred", ones, 16);
    wait_strobe(n);
    @(negedge clk);
    prev  = int'(PWM_OUT);
    ones  = 0;
    trans = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ones += int'(PWM_OUT);
      if (i > 0 && int'(PWM_OUT) != prev) trans++;
      prev = int'(PWM_OUT);
    end
    check("sd128_ones", ones, 8);
    check("sd128_toggles", trans, 15);
    send(8'd64, 2'd0);
    wait_strobe(n);
    @(negedge clk);
    count_high(16, ones);
    check("sd64_ones", ones, 4);

    // Stop, then run with div=3: ticks every 4 clocks, 1024-clock periods.
    enable = 1'b0;
    mode   = 1'b0;
    count_high(8, ones);
    check("disabled_low", ones, 0);
    div    = 4'd3;
    enable = 1'b1;
    wait_strobe(n);
    check("div3_first_boundary", n, 1023);
    wait_strobe(n);
    check("div3_period_a", n, 1024);
    prev  = int'(PWM_OUT);
    trans = 0;
    offp  = 0;
    per   = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (int'(PWM_OUT) != prev) begin
        trans++;
        if (i % 4 != 1) offp++;
      end
      prev = int'(PWM_OUT);
      if (period_strobe) begin
        per = i;
        break;
      end
    end
    check("div3_period_b", per, 1024);
    check("div3_transitions", trans, 2);
    check("div3_off_tick_changes", offp, 0);

    // Reset mid-period with output high, underrun set and buffer full.
    enable = 1'b0;
    div    = 4'd0;
    @(negedge clk);
    enable = 1'b1;
    wait_strobe(n);
    check("reenable_boundary", n, 255);
    repeat (10) @(negedge clk);
    check("pre_rst_pwm", int'(PWM_OUT), 1);
    check("pre_rst_underrun", int'(underrun), 1);
    send(8'd200, 2'd0);
    check("pre_rst_full", int'(bus.sample_ready), 0);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    check("midrst_pwm", int'(PWM_OUT), 0);
    check("midrst_ready", int'(bus.sample_ready), 1);
    check("midrst_underrun", int'(underrun), 0);
    check("midrst_strobe", int'(period_strobe), 0);
    wait_strobe(n);
    check("midrst_cnt_restart", n, 255);
    count_high(256, ones);
    check("midrst_duty_cleared", ones, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
